// File: rtl/sub_eq_sched_if.sv
// Sample stream bundle for the equalizer subcarrier scheduler.
//   ival/isop/sub_i/sub_q   : FFT sample stream into the scheduler
//   oval/osop/oindex/osub_* : tagged, 1-cycle delayed stream towards the equalizer
// The slave modport is the scheduler side; master is the FFT source / equalizer sink side.
interface sub_eq_sched_if #(
    parameter int fft_depth = 12
);
    logic                        ival;
    logic                        isop;
    logic signed [fft_depth-1:0] sub_i;
    logic signed [fft_depth-1:0] sub_q;
    logic                        oval;
    logic                        osop;
    logic [1:0]                  oindex;
    logic signed [fft_depth-1:0] osub_i;
    logic signed [fft_depth-1:0] osub_q;

    modport master (
        output ival, isop, sub_i, sub_q,
        input  oval, osop, oindex, osub_i, osub_q
    );

    modport slave (
        input  ival, isop, sub_i, sub_q,
        output oval, osop, oindex, osub_i, osub_q
    );
endinterface

// File: rtl/sub_eq_sched.sv
// Subcarrier scheduler for the receive equalizer.
// Frames each FFT symbol as lower guard / active pilot+data region / upper guard,
// tags every forwarded sample with a carrier class (0 null, 1 data, 2 pilot),
// moves start-of-symbol to the first active carrier, flags short and long
// symbols and counts complete symbols.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   bus       : sample stream in/out (sub_eq_sched_if.slave)
//   sym_cnt   : number of complete symbols, wraps
//   err_short : one-cycle pulse, symbol restarted by isop before it completed
//   err_long  : one-cycle pulse, sample arrived after a complete symbol without isop
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no symbol in progress, samples dropped until ival&isop
// GUARD_LO | next sample is a lower guard carrier (oindex 0)
// ACTIVE   | next sample is in the pilot/data region (oindex 2 or 1)
// GUARD_HI | next sample is an upper guard carrier (oindex 0)
// WAIT     | symbol complete, only ival&isop is legal next
module sub_eq_sched #(
    parameter int fft_depth  = 12,
    parameter int n_fft      = 1024,
    parameter int n_guard_lo = 112,
    parameter int step_pilot = 4,
    parameter int n_pilot    = 200
) (
    input  logic          clk,
    input  logic          rst,
    sub_eq_sched_if.slave bus,
    output logic [15:0]   sym_cnt,
    output logic          err_short,
    output logic          err_long
);

    localparam int n_active   = n_pilot * step_pilot;
    localparam int n_guard_hi = n_fft - n_guard_lo - n_active;
    localparam int smp_w      = $clog2(n_fft + 1);
    localparam int grp_w      = $clog2(step_pilot + 1);
    localparam int pil_w      = $clog2(n_pilot + 1);

    // With no lower guard this value is all ones and can never match, which is
    // fine because the symbol then starts directly in ACTIVE.
    localparam logic [smp_w-1:0] smp_glo_last = smp_w'(n_guard_lo - 1);
    localparam logic [smp_w-1:0] smp_last     = smp_w'(n_fft - 1);
    localparam logic [grp_w-1:0] grp_last     = grp_w'(step_pilot - 1);
    localparam logic [pil_w-1:0] pil_last     = pil_w'(n_pilot - 1);

    if (n_guard_hi < 0) begin : g_bad_guard
        $error("sub_eq_sched: n_guard_lo + n_pilot*step_pilot exceeds n_fft");
    end
    if (step_pilot < 2) begin : g_bad_step
        $error("sub_eq_sched: step_pilot must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUARD_LO,
        S_ACTIVE,
        S_GUARD_HI,
        S_WAIT
    } state_t;

    localparam state_t start_state = (n_guard_lo == 0) ? S_ACTIVE : S_GUARD_LO;
    localparam state_t after_active = (n_guard_hi == 0) ? S_WAIT : S_GUARD_HI;

    state_t           state_q, state_d, cur_state;
    logic [smp_w-1:0] smp_q, smp_d, cur_smp;
    logic [grp_w-1:0] grp_q, grp_d, cur_grp;
    logic [pil_w-1:0] pil_q, pil_d, cur_pil;

    logic       accept;
    logic [1:0] idx_d;
    logic       sop_d;
    logic       es_d;
    logic       el_d;
    logic       done_d;
    logic       done_q;

    // The registered state and counters describe the position of the next
    // sample. An isop sample overrides them with position 0 of a fresh symbol,
    // so the restart sample itself is classified and advanced like any other.
    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        grp_d     = grp_q;
        pil_d     = pil_q;
        cur_state = state_q;
        cur_smp   = smp_q;
        cur_grp   = grp_q;
        cur_pil   = pil_q;
        accept    = 1'b0;
        idx_d     = 2'd0;
        sop_d     = 1'b0;
        es_d      = 1'b0;
        el_d      = 1'b0;

        if (bus.ival) begin
            if (bus.isop) begin
                es_d      = (state_q == S_GUARD_LO) || (state_q == S_ACTIVE) ||
                            (state_q == S_GUARD_HI);
                cur_state = start_state;
                cur_smp   = '0;
                cur_grp   = '0;
                cur_pil   = '0;
            end

            case (cur_state)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_WAIT: begin
                    el_d    = 1'b1;
                    state_d = S_IDLE;
                end
                S_GUARD_LO: begin
                    accept  = 1'b1;
                    smp_d   = cur_smp + 1'b1;
                    grp_d   = '0;
                    pil_d   = '0;
                    state_d = (cur_smp == smp_glo_last) ? S_ACTIVE : S_GUARD_LO;
                end
                S_ACTIVE: begin
                    accept  = 1'b1;
                    smp_d   = cur_smp + 1'b1;
                    idx_d   = (cur_grp == '0) ? 2'd2 : 2'd1;
                    sop_d   = (cur_grp == '0) && (cur_pil == '0);
                    state_d = S_ACTIVE;
                    pil_d   = cur_pil;
                    if (cur_grp == grp_last) begin
                        grp_d = '0;
                        if (cur_pil == pil_last) begin
                            state_d = after_active;
                        end else begin
                            pil_d = cur_pil + 1'b1;
                        end
                    end else begin
                        grp_d = cur_grp + 1'b1;
                    end
                end
                S_GUARD_HI: begin
                    accept  = 1'b1;
                    smp_d   = cur_smp + 1'b1;
                    grp_d   = cur_grp;
                    pil_d   = cur_pil;
                    state_d = (cur_smp == smp_last) ? S_WAIT : S_GUARD_HI;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // WAIT is only ever entered on an accepted sample, so this is the
        // last-carrier-of-symbol event.
        done_d = accept && (state_d == S_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            smp_q      <= '0;
            grp_q      <= '0;
            pil_q      <= '0;
            bus.oval   <= 1'b0;
            bus.osop   <= 1'b0;
            bus.oindex <= 2'd0;
            bus.osub_i <= '0;
            bus.osub_q <= '0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            done_q     <= 1'b0;
            sym_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            smp_q      <= smp_d;
            grp_q      <= grp_d;
            pil_q      <= pil_d;
            bus.oval   <= accept;
            bus.osop   <= sop_d;
            bus.oindex <= idx_d;
            if (accept) begin
                bus.osub_i <= bus.sub_i;
                bus.osub_q <= bus.sub_q;
            end
            err_short  <= es_d;
            err_long   <= el_d;
            // Count lands one cycle after the last carrier leaves the block.
            done_q     <= done_d;
            if (done_q) begin
                sym_cnt <= sym_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sub_eq_sched.sv
module tb_sub_eq_sched;

    localparam int FD = 12;
    localparam int NF = 16;
    localparam int SP = 4;
    localparam int NP = 3;
    localparam int GA = 2;
    localparam int GB = 0;

    typedef struct {
        bit         v;
        bit         sop;
        logic [1:0] idx;
        logic [11:0] i;
        logic [11:0] q;
        bit         es;
        bit         el;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sub_eq_sched_if #(.fft_depth(FD)) bus_a ();
    sub_eq_sched_if #(.fft_depth(FD)) bus_b ();

    logic [15:0] sym_a, sym_b;
    logic        es_a, el_a, es_b, el_b;

    sub_eq_sched #(.fft_depth(FD), .n_fft(NF), .n_guard_lo(GA), .step_pilot(SP), .n_pilot(NP)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .sym_cnt(sym_a), .err_short(es_a), .err_long(el_a)
    );

    sub_eq_sched #(.fft_depth(FD), .n_fft(NF), .n_guard_lo(GB), .step_pilot(SP), .n_pilot(NP)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .sym_cnt(sym_b), .err_short(es_b), .err_long(el_b)
    );

    logic [1:0] tag_tbl [16] = '{0, 0, 2, 1, 1, 1, 2, 1, 1, 1, 2, 1, 1, 1, 0, 0};

    exp_t        sbq[$];
    int          pos_a = -1, pos_b = -1;
    int          exp_sym_a = 0, exp_sym_b = 0;
    int          n_chk = 0, n_fail = 0;
    logic [29:0] obs_w;
    logic [15:0] obs_sym;

    // Reference classification by absolute position in the symbol.
    function automatic logic [1:0] cls(input int pos, input int g);
        if (pos < g) return 2'd0;
        if (pos < g + NP * SP) return (((pos - g) % SP) == 0) ? 2'd2 : 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [29:0] pack(input exp_t e);
        return {e.v, e.v & e.sop, e.v ? e.idx : 2'b00, e.v ? e.i : 12'h000,
                e.v ? e.q : 12'h000, e.es, e.el};
    endfunction

    // Drive one cycle on the selected DUT, push its expected result, sample after the edge.
    task automatic cycle(input bit sel, input bit v, input bit s, output bit had);
        logic [11:0] di, dq;
        int   g, pos;
        exp_t e;
        di  = 12'($urandom);
        dq  = 12'($urandom);
        g   = sel ? GB : GA;
        pos = sel ? pos_b : pos_a;
        bus_a.ival = !sel && v;  bus_a.isop = !sel && s;  bus_a.sub_i = di;  bus_a.sub_q = dq;
        bus_b.ival = sel && v;   bus_b.isop = sel && s;   bus_b.sub_i = di;  bus_b.sub_q = dq;
        had = v;
        if (v) begin
            e = '{v: 1'b0, sop: 1'b0, idx: 2'd0, i: di, q: dq, es: 1'b0, el: 1'b0};
            if (s) begin
                e.es  = (pos >= 0) && (pos < NF);
                e.v   = 1'b1;
                e.sop = (g == 0);
                e.idx = cls(0, g);
                pos   = 1;
            end else if (pos == NF) begin
                e.el = 1'b1;
                pos  = -1;
            end else if (pos >= 0) begin
                e.v   = 1'b1;
                e.sop = (pos == g);
                e.idx = cls(pos, g);
                pos++;
                if (pos == NF) begin
                    if (sel) exp_sym_b++; else exp_sym_a++;
                end
            end
            sbq.push_back(e);
        end
        if (sel) pos_b = pos; else pos_a = pos;
        @(posedge clk);
        #1;
        if (sel) begin
            obs_w   = {bus_b.oval, bus_b.osop, bus_b.oval ? bus_b.oindex : 2'b00,
                       bus_b.oval ? 12'(bus_b.osub_i) : 12'h000,
                       bus_b.oval ? 12'(bus_b.osub_q) : 12'h000, es_b, el_b};
            obs_sym = sym_b;
        end else begin
            obs_w   = {bus_a.oval, bus_a.osop, bus_a.oval ? bus_a.oindex : 2'b00,
                       bus_a.oval ? 12'(bus_a.osub_i) : 12'h000,
                       bus_a.oval ? 12'(bus_a.osub_q) : 12'h000, es_a, el_a};
            obs_sym = sym_a;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_a.ival = 1'b1; bus_a.isop = 1'b1; bus_a.sub_i = 12'h5a5; bus_a.sub_q = 12'h3c3;
        bus_b.ival = 1'b1; bus_b.isop = 1'b1; bus_b.sub_i = 12'h5a5; bus_b.sub_q = 12'h3c3;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({bus_a.oval, bus_a.osop, bus_a.oindex, bus_a.osub_i, bus_a.osub_q, es_a, el_a, sym_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got oval=%b osop=%b idx=%0d i=%h q=%h es=%b el=%b sym=%0d, expected all zero",
                     bus_a.oval, bus_a.osop, bus_a.oindex, bus_a.osub_i, bus_a.osub_q, es_a, el_a, sym_a);
        end
        n_chk++;
        if ({bus_b.oval, bus_b.osop, bus_b.oindex, bus_b.osub_i, bus_b.osub_q, es_b, el_b, sym_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got oval=%b osop=%b idx=%0d i=%h q=%h es=%b el=%b sym=%0d, expected all zero",
                     bus_b.oval, bus_b.osop, bus_b.oindex, bus_b.osub_i, bus_b.osub_q, es_b, el_b, sym_b);
        end
        bus_a.ival = 1'b0; bus_a.isop = 1'b0;
        bus_b.ival = 1'b0; bus_b.isop = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit          had;
        logic [29:0] ew;
        int          sop_pos[$];
        for (int k = 0; k < 2 * NF; k++) begin
            cycle(0, 1'b1, (k % NF) == 0, had);
            ew = had ? pack(sbq.pop_front()) : '0;
            n_chk++;
            if (obs_w !== ew) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h expected %h", k, obs_w, ew);
            end
            n_chk++;
            if (obs_w[27:26] !== tag_tbl[k % NF]) begin
                n_fail++;
                $display("FAIL b2b_tag[%0d]: got %0d expected %0d", k, obs_w[27:26], tag_tbl[k % NF]);
            end
            if (obs_w[28]) sop_pos.push_back(k);
        end
        n_chk++;
        if (obs_sym !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_sym_lag: got %0d expected 1", obs_sym);
        end
        n_chk++;
        if (sop_pos.size() != 2 || sop_pos[0] != 2 || sop_pos[1] != NF + 2) begin
            n_fail++;
            $display("FAIL b2b_sop: got %0d sop pulses (first at %0d) expected 2 at 2 and 18",
                     sop_pos.size(), sop_pos.size() > 0 ? sop_pos[0] : -1);
        end
        cycle(0, 1'b0, 1'b0, had);
        n_chk++;
        if (obs_sym !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_sym: got %0d expected 2", obs_sym);
        end
    endtask

    task automatic test_gaps();
        bit          had;
        logic [29:0] ew;
        logic [1:0]  tags[$];
        for (int k = 0; k < 2 * NF; k++) begin
            int gaps;
            gaps = (k == 5) ? 2 : int'($urandom_range(0, 2));
            for (int j = 0; j < gaps; j++) begin
                cycle(0, 1'b0, 1'b0, had);
                n_chk++;
                if (obs_w !== 30'h0) begin
                    n_fail++;
                    $display("FAIL gap_idle[%0d]: got %h expected 0", k, obs_w);
                end
            end
            cycle(0, 1'b1, (k % NF) == 0, had);
            ew = had ? pack(sbq.pop_front()) : '0;
            n_chk++;
            if (obs_w !== ew) begin
                n_fail++;
                $display("FAIL gap[%0d]: got %h expected %h", k, obs_w, ew);
            end
            if (obs_w[29]) tags.push_back(obs_w[27:26]);
        end
        for (int k = 0; k < 2 * NF; k++) begin
            n_chk++;
            if (k >= tags.size() || tags[k] !== tag_tbl[k % NF]) begin
                n_fail++;
                $display("FAIL gap_tag[%0d]: got %0d expected %0d", k,
                         k < tags.size() ? tags[k] : 2'd3, tag_tbl[k % NF]);
            end
        end
        repeat (2) cycle(0, 1'b0, 1'b0, had);
        n_chk++;
        if (obs_sym !== 16'(exp_sym_a)) begin
            n_fail++;
            $display("FAIL gap_sym: got %0d expected %0d", obs_sym, exp_sym_a);
        end
    endtask

    task automatic test_short();
        bit          had;
        logic [29:0] ew;
        int          n_es = 0;
        int          sym0;
        sym0 = exp_sym_a;
        for (int k = 0; k < 9 + NF; k++) begin
            cycle(0, 1'b1, (k == 0) || (k == 9), had);
            ew = had ? pack(sbq.pop_front()) : '0;
            n_chk++;
            if (obs_w !== ew) begin
                n_fail++;
                $display("FAIL short[%0d]: got %h expected %h", k, obs_w, ew);
            end
            if (obs_w[1]) n_es++;
        end
        n_chk++;
        if (n_es != 1) begin
            n_fail++;
            $display("FAIL short_pulses: got %0d expected 1", n_es);
        end
        repeat (2) cycle(0, 1'b0, 1'b0, had);
        n_chk++;
        if (obs_sym !== 16'(sym0 + 1)) begin
            n_fail++;
            $display("FAIL short_sym: got %0d expected %0d", obs_sym, sym0 + 1);
        end
    endtask

    task automatic test_long();
        bit          had;
        logic [29:0] ew;
        int          n_el = 0;
        // 17-sample symbol, one more stray sample, then a normal symbol
        for (int k = 0; k < 18 + NF; k++) begin
            cycle(0, 1'b1, (k == 0) || (k == 18), had);
            ew = had ? pack(sbq.pop_front()) : '0;
            n_chk++;
            if (obs_w !== ew) begin
                n_fail++;
                $display("FAIL long[%0d]: got %h expected %h", k, obs_w, ew);
            end
            if (obs_w[0]) n_el++;
        end
        n_chk++;
        if (n_el != 1) begin
            n_fail++;
            $display("FAIL long_pulses: got %0d expected 1", n_el);
        end
        repeat (2) cycle(0, 1'b0, 1'b0, had);
        n_chk++;
        if (obs_sym !== 16'(exp_sym_a)) begin
            n_fail++;
            $display("FAIL long_sym: got %0d expected %0d", obs_sym, exp_sym_a);
        end
    endtask

    task automatic test_guard0();
        bit          had;
        logic [29:0] ew;
        for (int k = 0; k < NF; k++) begin
            cycle(1, 1'b1, k == 0, had);
            ew = had ? pack(sbq.pop_front()) : '0;
            n_chk++;
            if (obs_w !== ew) begin
                n_fail++;
                $display("FAIL guard0[%0d]: got %h expected %h", k, obs_w, ew);
            end
            if (k == 0) begin
                n_chk++;
                if (obs_w[29:26] !== 4'b1110) begin
                    n_fail++;
                    $display("FAIL guard0_sop: got oval/osop/idx=%b expected 1110", obs_w[29:26]);
                end
            end
        end
        repeat (2) cycle(1, 1'b0, 1'b0, had);
        n_chk++;
        if (obs_sym !== 16'd1) begin
            n_fail++;
            $display("FAIL guard0_sym: got %0d expected 1", obs_sym);
        end
    endtask

    task automatic test_reset_mid();
        bit          had;
        logic [29:0] ew;
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1'b1, k == 0, had);
            ew = had ? pack(sbq.pop_front()) : '0;
            n_chk++;
            if (obs_w !== ew) begin
                n_fail++;
                $display("FAIL rmid_pre[%0d]: got %h expected %h", k, obs_w, ew);
            end
        end
        rst = 1'b1;
        bus_a.ival = 1'b1; bus_a.isop = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pos_a = -1;
        exp_sym_a = 0;
        sbq.delete();
        n_chk++;
        if ({bus_a.oval, es_a, el_a, sym_a} !== 19'h0) begin
            n_fail++;
            $display("FAIL rmid_rst: got oval=%b es=%b el=%b sym=%0d expected all zero",
                     bus_a.oval, es_a, el_a, sym_a);
        end
        for (int k = 0; k < 3 + NF; k++) begin
            cycle(0, 1'b1, k == 3, had);
            ew = had ? pack(sbq.pop_front()) : '0;
            n_chk++;
            if (obs_w !== ew) begin
                n_fail++;
                $display("FAIL rmid[%0d]: got %h expected %h", k, obs_w, ew);
            end
        end
        repeat (2) cycle(0, 1'b0, 1'b0, had);
        n_chk++;
        if (obs_sym !== 16'd1) begin
            n_fail++;
            $display("FAIL rmid_sym: got %0d expected 1", obs_sym);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_a.ival = 1'b0; bus_a.isop = 1'b0; bus_a.sub_i = '0; bus_a.sub_q = '0;
        bus_b.ival = 1'b0; bus_b.isop = 1'b0; bus_b.sub_i = '0; bus_b.sub_q = '0;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_short();
        test_long();
        test_guard0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
